// File: rtl/smbus_target_pkg.sv
// Shared types and constants for the SMBus target.
package smbus_target_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [6:0]       DEFAULT_ADDRESS = 7'h5A;
  localparam logic             ACK             = 1'b0;
  localparam logic             NACK            = 1'b1;
  localparam logic [CNT_W-1:0] LAST_BIT        = CNT_W'(7);
  localparam logic [CNT_W-1:0] BYTE_DONE       = CNT_W'(8);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CMD,
    ST_CMD_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_IGNORE
  } state_t;

  // Decoded bus conditions, one clock wide, plus the synchronized SDA level.
  typedef struct packed {
    logic start;
    logic stop;
    logic rise;
    logic fall;
    logic sda;
  } bus_evt_t;

endpackage

// File: rtl/smbus_target_sync_edge.sv
// Pin synchronizers and START/STOP/SCL-edge decode for the SMBus target.
module smbus_target_sync_edge
  import smbus_target_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_scl,
  input  logic     i_sda,
  output bus_evt_t o_evt
);

  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] r_scl_sync;
  logic [STAGES-1:0] r_sda_sync;
  logic              r_scl_hist;
  logic              r_sda_hist;
  bus_evt_t          r_evt;
  logic              w_scl;
  logic              w_sda;

  assign w_scl = r_scl_sync[STAGES-1];
  assign w_sda = r_sda_sync[STAGES-1];
  assign o_evt = r_evt;

  // Synchronizer chains and history flops; the bus idles high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[STAGES-2:0], i_sda};
      r_scl_hist <= w_scl;
      r_sda_hist <= w_sda;
    end
  end

  // Registered event pulses, aligned with the SDA level they were decoded from.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_evt <= '{start: 1'b0, stop: 1'b0, rise: 1'b0, fall: 1'b0, sda: 1'b1};
    end else begin
      r_evt.start <= w_scl & r_scl_hist & r_sda_hist & ~w_sda;
      r_evt.stop  <= w_scl & r_scl_hist & ~r_sda_hist & w_sda;
      r_evt.rise  <= w_scl & ~r_scl_hist;
      r_evt.fall  <= ~w_scl & r_scl_hist;
      r_evt.sda   <= w_sda;
    end
  end

endmodule

// File: rtl/smbus_target.sv
// SMBus target with a byte-wide register-file port and auto-incrementing pointer.
module smbus_target
  import smbus_target_pkg::*;
#(
  parameter logic [6:0]  ADDRESS     = DEFAULT_ADDRESS,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned PW         = $clog2(NUM_REGS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              SMBusClock,
  input  logic              SMBusData,
  output logic              SMBusDataDrive,
  output logic [PW-1:0]     RegAddr,
  output logic [BYTE_W-1:0] RegWriteData,
  output logic              RegWrite,
  input  logic [BYTE_W-1:0] RegReadData,
  output logic              Busy
);

  bus_evt_t          w_evt;
  logic [BYTE_W-1:0] w_byte;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BYTE_W-1:0] r_shift;
  logic [PW-1:0]     r_ptr;
  logic              r_drive;
  logic              r_busy;
  logic [BYTE_W-1:0] r_wdata;
  logic              r_wr;
  logic              r_inc;
  logic              r_phase;
  logic              r_rw;

  smbus_target_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_scl   (SMBusClock),
    .i_sda   (SMBusData),
    .o_evt   (w_evt)
  );

  // Byte as it stands once the current RISE sample is shifted in.
  assign w_byte = {r_shift[BYTE_W-2:0], w_evt.sda};

  assign SMBusDataDrive = r_drive;
  assign RegAddr        = r_ptr;
  assign RegWriteData   = r_wdata;
  assign RegWrite       = r_wr;
  assign Busy           = r_busy;

  // Protocol FSM with bit counter, shift register, pointer and registered outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_ptr   <= '0;
      r_drive <= 1'b0;
      r_busy  <= 1'b0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_inc   <= 1'b0;
      r_phase <= 1'b0;
      r_rw    <= 1'b0;
    end else begin
      r_wr  <= 1'b0;
      r_inc <= 1'b0;
      if (r_inc) begin
        r_ptr <= r_ptr + PW'(1);
      end

      if (w_evt.start || w_evt.stop) begin
        // Bus conditions override any state and drop partial bytes.
        r_state <= w_evt.start ? ST_ADDR : ST_IDLE;
        r_drive <= 1'b0;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
        r_phase <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_IGNORE: begin
            r_drive <= 1'b0;
          end

          ST_ADDR, ST_CMD, ST_WRITE: begin
            if (w_evt.rise) begin
              r_shift <= w_byte;
              if (r_cnt == LAST_BIT) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
                case (r_state)
                  ST_ADDR: begin
                    r_rw    <= w_evt.sda;
                    r_state <= (w_byte[BYTE_W-1:1] == ADDRESS) ? ST_ADDR_ACK : ST_IGNORE;
                  end
                  ST_CMD: begin
                    r_ptr   <= w_byte[PW-1:0];
                    r_state <= ST_CMD_ACK;
                  end
                  default: begin
                    r_wdata <= w_byte;
                    r_wr    <= 1'b1;
                    r_inc   <= 1'b1;
                    r_state <= ST_WRITE_ACK;
                  end
                endcase
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end

          ST_ADDR_ACK, ST_CMD_ACK, ST_WRITE_ACK: begin
            // First FALL pulls SDA for the ACK slot, second FALL ends it.
            if (w_evt.fall) begin
              if (!r_phase) begin
                r_drive <= 1'b1;
                r_phase <= 1'b1;
                if (r_state == ST_ADDR_ACK) begin
                  r_busy <= 1'b1;
                end
              end else begin
                r_phase <= 1'b0;
                if (r_state == ST_ADDR_ACK && r_rw) begin
                  r_shift <= RegReadData;
                  r_drive <= ~RegReadData[BYTE_W-1];
                  r_ptr   <= r_ptr + PW'(1);
                  r_cnt   <= '0;
                  r_state <= ST_READ;
                end else begin
                  r_drive <= 1'b0;
                  r_state <= (r_state == ST_ADDR_ACK) ? ST_CMD : ST_WRITE;
                end
              end
            end
          end

          ST_READ: begin
            // MSB is already on the bus; each FALL presents the next bit.
            if (w_evt.rise) begin
              if (r_cnt == LAST_BIT) begin
                r_cnt <= BYTE_DONE;
              end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_shift <= {r_shift[BYTE_W-2:0], 1'b0};
              end
            end else if (w_evt.fall) begin
              if (r_cnt == BYTE_DONE) begin
                r_drive <= 1'b0;
                r_cnt   <= '0;
                r_phase <= 1'b0;
                r_state <= ST_READ_ACK;
              end else begin
                r_drive <= ~r_shift[BYTE_W-1];
              end
            end
          end

          ST_READ_ACK: begin
            // Master ACK continues the read with the next register.
            if (w_evt.rise) begin
              if (w_evt.sda == NACK) begin
                r_state <= ST_IGNORE;
              end else begin
                r_phase <= 1'b1;
              end
            end else if (w_evt.fall && r_phase) begin
              r_phase <= 1'b0;
              r_shift <= RegReadData;
              r_drive <= ~RegReadData[BYTE_W-1];
              r_ptr   <= r_ptr + PW'(1);
              r_cnt   <= '0;
              r_state <= ST_READ;
            end
          end

          default: begin
            r_drive <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_smbus_target.sv
// Scoreboard bench for smbus_target: bus-frame and register-write monitors.
module tb_smbus_target;

  localparam int unsigned PW = 4;
  localparam int unsigned Q  = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          scl_m = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_bus;
  logic          SMBusDataDrive;
  logic [PW-1:0] RegAddr;
  logic [7:0]    RegWriteData;
  logic          RegWrite;
  logic [7:0]    RegReadData;
  logic          Busy;

  logic [7:0]    mem [16];
  int            n_tests = 0;
  int            n_fail  = 0;

  logic [8:0]    exp_frames [$];
  logic [11:0]   exp_wr [$];

  logic          quiet_win = 1'b0;
  logic          quiet_bad = 1'b0;

  assign sda_bus     = sda_m & ~SMBusDataDrive;
  assign RegReadData = mem[RegAddr];

  always #5 Clock = ~Clock;

  smbus_target dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .SMBusClock     (scl_m),
    .SMBusData      (sda_bus),
    .SMBusDataDrive (SMBusDataDrive),
    .RegAddr        (RegAddr),
    .RegWriteData   (RegWriteData),
    .RegWrite       (RegWrite),
    .RegReadData    (RegReadData),
    .Busy           (Busy)
  );

  always @(posedge Clock) begin
    if (RegWrite) mem[RegAddr] <= RegWriteData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  // Bus monitor: frames of 8 data bits plus the ACK slot, reset by START/STOP.
  logic       m_scl_p = 1'b1;
  logic       m_sda_p = 1'b1;
  int         m_bits  = 0;
  logic [8:0] m_frame = '0;
  always @(negedge Clock) begin
    if (scl_m && m_scl_p && (m_sda_p != sda_bus)) begin
      m_bits = 0;
    end else if (scl_m && !m_scl_p) begin
      m_frame = {m_frame[7:0], sda_bus};
      m_bits++;
      if (m_bits == 9) begin
        m_bits = 0;
        if (exp_frames.size() == 0) unexpected("frame_unexpected", m_frame);
        else check("frame", m_frame, exp_frames.pop_front());
      end
    end
    m_scl_p = scl_m;
    m_sda_p = sda_bus;
  end

  // Register-write monitor.
  always @(negedge Clock) begin
    if (RegWrite) begin
      if (exp_wr.size() == 0) unexpected("regwrite_unexpected", {RegAddr, RegWriteData});
      else check("regwrite", {RegAddr, RegWriteData}, exp_wr.pop_front());
    end
  end

  always @(negedge Clock) begin
    if (quiet_win && (Busy || SMBusDataDrive || RegWrite)) quiet_bad <= 1'b1;
  end

  task automatic q_wait();
    repeat (Q) @(posedge Clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    q_wait();
    scl_m = 1'b1;
    q_wait();
    q_wait();
    scl_m = 1'b0;
    q_wait();
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    q_wait();
    scl_m = 1'b1;
    q_wait();
    sda_m = 1'b0;
    q_wait();
    scl_m = 1'b0;
    q_wait();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    q_wait();
    scl_m = 1'b1;
    q_wait();
    sda_m = 1'b1;
    q_wait();
    q_wait();
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic ack);
    exp_frames.push_back({b, ack});
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(1'b1);
  endtask

  task automatic rd_byte(input logic [7:0] exp, input logic mack);
    exp_frames.push_back({exp, mack});
    repeat (8) send_bit(1'b1);
    send_bit(mack);
  endtask

  task automatic t1_write();
    exp_wr.push_back({4'd3, 8'hA5});
    exp_wr.push_back({4'd4, 8'h3C});
    bus_start();
    wr_byte(8'hB4, 1'b0);
    check("t1_busy_high", Busy, 1'b1);
    wr_byte(8'h03, 1'b0);
    wr_byte(8'hA5, 1'b0);
    wr_byte(8'h3C, 1'b0);
    bus_stop();
    check("t1_busy_low", Busy, 1'b0);
    check("t1_ptr", RegAddr, 4'd5);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[7] = 8'hC3;
    mem[8] = 8'h5E;

    Reset = 1'b0;
    #1;
    check("rst_drive", SMBusDataDrive, 1'b0);
    check("rst_addr", RegAddr, 4'd0);
    check("rst_wdata", RegWriteData, 8'h00);
    check("rst_write", RegWrite, 1'b0);
    check("rst_busy", Busy, 1'b0);
    repeat (3) @(posedge Clock);
    #2;
    Reset = 1'b1;
    q_wait();

    // T1: plain write of two registers
    t1_write();
    check("t1_mem3", mem[3], 8'hA5);
    check("t1_mem4", mem[4], 8'h3C);

    // T2: combined write-then-read of registers 7 and 8
    bus_start();
    wr_byte(8'hB4, 1'b0);
    wr_byte(8'h07, 1'b0);
    bus_start();
    wr_byte(8'hB5, 1'b0);
    rd_byte(8'hC3, 1'b0);
    rd_byte(8'h5E, 1'b1);
    bus_stop();
    check("t2_ptr", RegAddr, 4'd9);
    check("t2_busy_low", Busy, 1'b0);

    // T3: foreign address is never acknowledged
    quiet_win = 1'b1;
    bus_start();
    wr_byte(8'h44, 1'b1);
    wr_byte(8'h11, 1'b1);
    bus_stop();
    quiet_win = 1'b0;
    check("t3_quiet", quiet_bad, 1'b0);

    // T4: pointer wraps from 15 to 0
    exp_wr.push_back({4'd15, 8'h11});
    exp_wr.push_back({4'd0, 8'h22});
    bus_start();
    wr_byte(8'hB4, 1'b0);
    wr_byte(8'h0F, 1'b0);
    wr_byte(8'h11, 1'b0);
    wr_byte(8'h22, 1'b0);
    bus_stop();
    check("t4_ptr", RegAddr, 4'd1);

    // T5: STOP after five bits of a data byte, then a fresh write
    bus_start();
    wr_byte(8'hB4, 1'b0);
    wr_byte(8'h03, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    bus_stop();
    check("t5_busy_low", Busy, 1'b0);
    check("t5_ptr", RegAddr, 4'd3);
    t1_write();

    // T6: reset while the target pulls SDA low during a read
    bus_start();
    wr_byte(8'hB4, 1'b0);
    wr_byte(8'h08, 1'b0);
    bus_start();
    wr_byte(8'hB5, 1'b0);
    repeat (3) @(posedge Clock);
    #2;
    check("t6_drive_before", SMBusDataDrive, 1'b1);
    Reset = 1'b0;
    #1;
    check("t6_drive", SMBusDataDrive, 1'b0);
    check("t6_addr", RegAddr, 4'd0);
    check("t6_wdata", RegWriteData, 8'h00);
    check("t6_busy", Busy, 1'b0);
    repeat (3) @(posedge Clock);
    #2;
    Reset = 1'b1;
    q_wait();
    bus_stop();
    t1_write();

    q_wait();
    check("frames_left", exp_frames.size(), 0);
    check("writes_left", exp_wr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
